// File: rtl/onehot_decoder.sv
// Registered W-to-2^W one-hot decoder with programmable per-step hold and a built-in sweep of all codes.
// One cycle from accept to Out; In_Ready is low whenever a step or sweep is in progress, or while Scan_Start is asserted.
module onehot_decoder #(
  parameter int W      = 4,
  parameter int HOLD_W = 4,
  localparam int N     = 1 << W
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic              In_Valid,
  output logic              In_Ready,
  input  logic [W-1:0]      In_Code,
  input  logic [HOLD_W-1:0] Hold,
  input  logic              Scan_Start,
  output logic [N-1:0]      Out,
  output logic              Out_Valid,
  output logic              Busy,
  output logic              Scan_Done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    SCAN = 2'd2
  } state_t;

  localparam logic [N-1:0] ONE      = {{(N-1){1'b0}}, 1'b1};
  localparam logic [W-1:0] LAST_IDX = W'(N - 1);

  state_t              state_q, state_d;
  logic [N-1:0]        out_q, out_d;
  logic                out_vld_q, out_vld_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic [HOLD_W-1:0]   cnt_q, cnt_d;
  logic [W-1:0]        idx_q, idx_d;

  // Scan_Start steals the idle cycle, so a code offered alongside it is refused.
  assign In_Ready  = Rst_n && (state_q == IDLE) && !Scan_Start;
  assign Out       = out_q;
  assign Out_Valid = out_vld_q;
  assign Busy      = busy_q;
  assign Scan_Done = done_q;

  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        out_d = '0;
        if (Scan_Start) begin
          state_d = SCAN;
          idx_d   = '0;
          out_d   = ONE;
          cnt_d   = Hold;
        end else if (In_Valid && In_Ready) begin
          state_d = HOLD;
          out_d   = ONE << In_Code;
          cnt_d   = Hold;
        end
      end
      HOLD: begin
        if (cnt_q == '0) begin
          state_d = IDLE;
          out_d   = '0;
        end else begin
          cnt_d = cnt_q - HOLD_W'(1);
        end
      end
      SCAN: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - HOLD_W'(1);
        end else if (idx_q == LAST_IDX) begin
          // Sweep ends at the top code; idx never wraps back to zero.
          state_d = IDLE;
          out_d   = '0;
          done_d  = 1'b1;
        end else begin
          idx_d = idx_q + W'(1);
          out_d = out_q << 1;
          cnt_d = Hold;
        end
      end
      default: begin
        state_d = IDLE;
        out_d   = '0;
      end
    endcase
    out_vld_d = |out_d;
    busy_d    = (state_d != IDLE);
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q   <= IDLE;
      out_q     <= '0;
      out_vld_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      cnt_q     <= '0;
      idx_q     <= '0;
    end else begin
      state_q   <= state_d;
      out_q     <= out_d;
      out_vld_q <= out_vld_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
    end
  end

endmodule

// File: doc/onehot_decoder.md
# onehot_decoder

Registered 4-to-16 one-hot decoder: the inverse of the team's priority/one-hot encoder. It accepts a binary code over a valid/ready handshake and drives the matching one-hot line for a programmable number of cycles. A built-in scan mode walks every code 0..N-1 in order, so the encoder/decoder pair can be round-trip tested in hardware. It sits between control logic producing binary select codes and one-hot-enabled downstream resources.

## Interface
- W, default 4: code width.
- N, derived as 1<<W (16): one-hot output width; not overridable.
- HOLD_W, default 4: width of the hold-length field.

- Clk  in  1  sole clock; all state updates on the rising edge.
- Rst_n  in  1  asynchronous, active-low reset; clears all state immediately.
- In_Valid  in  1  In_Code is valid this cycle.
- In_Ready  out  1  block accepts a code this cycle.
- In_Code  in  W  binary code to decode.
- Hold  in  HOLD_W  extra cycles each output step is held; a step lasts Hold+1 cycles.
- Scan_Start  in  1  request an automatic sweep of all codes.
- Out  out  N  one-hot result; numerically equal to 1<<code, so Out[0] is code 0.
- Out_Valid  out  1  high exactly when Out is non-zero.
- Busy  out  1  state is not IDLE.
- Scan_Done  out  1  single-cycle pulse when a sweep completes.

## Operation
- States: IDLE, HOLD, SCAN. Registers: state, Out, hold counter cnt (HOLD_W bits), scan index idx (W bits).
- In_Ready = Rst_n && state==IDLE && !Scan_Start (combinational).
- IDLE:
  - If Scan_Start=1: go to SCAN, idx<=0, Out<=1, cnt<=Hold.
  - Else, on accept (In_Valid && In_Ready): go to HOLD, Out<=1<<In_Code, cnt<=Hold.
  - Otherwise Out stays 0.
  - Scan_Start has priority over In_Valid; a code presented in the same cycle is not accepted.
- HOLD:
  - If cnt==0: Out<=0 and go to IDLE.
  - Else cnt<=cnt-1.
  - In_Valid and Scan_Start are ignored.
- SCAN, when cnt==0:
  - If idx==N-1: Out<=0, Scan_Done<=1, go to IDLE.
  - Else idx<=idx+1, Out<=Out<<1, cnt<=Hold.
  - In SCAN, cnt!=0: cnt<=cnt-1.
- Hold is sampled only when a step starts (at accept, scan start, or scan advance). Changes during a step have no effect on that step.
- Out is always all-zero or exactly one bit set. Out_Valid = |Out, registered alongside Out.
- Scan_Done is high for exactly one cycle, in the same cycle state returns to IDLE. It is 0 at all other times.
- Busy is registered and equals state!=IDLE.

## Timing
- Reset (Rst_n low, asynchronous): state=IDLE, Out=0, Out_Valid=0, Busy=0, Scan_Done=0, cnt=0, idx=0, In_Ready=0. In_Ready rises in the same cycle Rst_n deasserts.
- Latency: a code accepted at edge k appears on Out after edge k, i.e. 1 cycle.
- Each step holds Out for Hold+1 cycles, then Out=0 for one IDLE cycle. Single-code throughput is one code per Hold+2 cycles.
- Scan: N·(Hold+1) cycles of one-hot output with no gaps between steps. Scan_Done and Out=0 follow on the next cycle.
- Reset asserted mid-HOLD or mid-SCAN: all outputs clear immediately. No Scan_Done pulse is produced.
- Code N-1 in HOLD and idx wrap: idx never wraps. The scan terminates at N-1.

## Test plan
- Reset: hold Rst_n=0 with In_Valid=1, In_Code=3 -> Out=0x0000, Out_Valid=0, Busy=0, In_Ready=0. Release -> In_Ready=1 the same cycle.
- Single decode: In_Code=5, Hold=0, one-cycle valid -> Out=0x0020 and Out_Valid=1 for exactly 1 cycle starting 1 cycle after accept, then Out=0 and In_Ready=1.
- Hold and back-to-back: Hold=3, codes 15 then 0 held valid -> Out=0x8000 for 4 cycles, 1 cycle of 0, then 0x0001 for 4 cycles. In_Ready low throughout each step. Changing Hold to 0 mid-step does not shorten it.
- Scan: Hold=0, pulse Scan_Start -> Out = 0x0001, 0x0002, … 0x8000 on 16 consecutive cycles, then Out=0 with Scan_Done=1 for 1 cycle. Busy is high for all 16 cycles.
- Priority: Scan_Start=1 and In_Valid=1 (code 9) in the same IDLE cycle -> In_Ready=0, scan starts at 0x0001, 0x0200 never appears out of sequence.
- Reset mid-scan: Hold=1, assert Rst_n=0 at step 6 (Out=0x0040) -> Out=0, Busy=0 asynchronously, no Scan_Done. After release, a new In_Code=2 decodes to 0x0004.
